// File: rtl/npc_lsu_pkg.sv
// npc_lsu_pkg: shared types, constants and helpers for the NPC load/store unit.
//   lsu_state_e    : LSU control state (IDLE, ACCESS, RESP)
//   F3_*           : RV32 load/store funct3 size/sign codes
//   lsu_f3_legal   : funct3 legality for a load or a store
//   lsu_misaligned : natural-alignment check for a funct3/address pair
package npc_lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Loads accept all five codes; stores have no unsigned variants.
    function automatic logic lsu_f3_legal(input logic wen, input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !wen;
            default:          return 1'b0;
        endcase
    endfunction

    // Bytes never misalign; halfwords need addr[0]=0; words need addr[1:0]=0.
    function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return addr_lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/npc_lsu_align.sv
// npc_lsu_align: combinational data alignment for the load/store unit.
//   st_funct3/st_addr_lo/st_data : store request (size, byte offset, right-justified data)
//   st_wdata/st_wmask            : lane-replicated store word and 4-bit byte mask
//   ld_funct3/ld_addr_lo/ld_word : load request and the raw word from memory
//   ld_data                      : extracted, sign- or zero-extended load result
module npc_lsu_align
    import npc_lsu_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wmask,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shifted;

    // Replicating the datum across lanes means the mask alone selects the
    // destination bytes; no data shifter is needed on the store path.
    always_comb begin
        st_wdata = st_data;
        st_wmask = 4'b1111;
        case (st_funct3)
            F3_B: begin
                st_wdata = {4{st_data[7:0]}};
                st_wmask = 4'b0001 << st_addr_lo;
            end
            F3_H: begin
                st_wdata = {2{st_data[15:0]}};
                st_wmask = 4'b0011 << st_addr_lo;
            end
            default: begin
                st_wdata = st_data;
                st_wmask = 4'b1111;
            end
        endcase
    end

    // Bring the addressed byte/halfword down to bit 0, then extend.
    assign ld_shifted = ld_word >> {ld_addr_lo, 3'b000};

    always_comb begin
        ld_data = ld_word;
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            F3_H:    ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            F3_BU:   ld_data = {24'h0, ld_shifted[7:0]};
            F3_HU:   ld_data = {16'h0, ld_shifted[15:0]};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/npc_lsu.sv
// npc_lsu: load/store unit driving the memory controller port of the NPC core.
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   req_*             : one load/store request from execute (valid/ready)
//   mem_*             : access port to the memory controller
//   resp_*            : result to write-back (valid/ready), one at a time
// Parameter MEM_LATENCY (>=1): cycles mem_valid is held per access.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The request side is ready only in IDLE; a response, once valid,
// keeps valid and its payload stable until it is taken. Ready raised before
// valid has no effect.
module npc_lsu
    import npc_lsu_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_valid,
    output logic        mem_wen,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    lsu_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             r_wen;
    logic [2:0]       r_funct3;
    logic [1:0]       r_addr_lo;

    logic             accept;
    logic             req_ok;
    logic             last_beat;
    logic [31:0]      st_wdata;
    logic [3:0]       st_wmask;
    logic [31:0]      ld_data;

    assign accept    = req_valid && req_ready;
    assign req_ok    = lsu_f3_legal(req_wen, req_funct3) &&
                       !lsu_misaligned(req_funct3, req_addr[1:0]);
    assign last_beat = (cnt == CNT_W'(1));

    // Store side aligns straight from the request so mem_wdata/mem_wmask can be
    // registered at accept; load side works on the latched request fields.
    npc_lsu_align u_align (
        .st_funct3  (req_funct3),
        .st_addr_lo (req_addr[1:0]),
        .st_data    (req_wdata),
        .st_wdata   (st_wdata),
        .st_wmask   (st_wmask),
        .ld_funct3  (r_funct3),
        .ld_addr_lo (r_addr_lo),
        .ld_word    (mem_rdata),
        .ld_data    (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            r_wen      <= 1'b0;
            r_funct3   <= 3'b000;
            r_addr_lo  <= 2'b00;
            req_ready  <= 1'b1;
            mem_valid  <= 1'b0;
            mem_wen    <= 1'b0;
            mem_raddr  <= 32'h0;
            mem_waddr  <= 32'h0;
            mem_wdata  <= 32'h0;
            mem_wmask  <= 8'h00;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        r_wen     <= req_wen;
                        r_funct3  <= req_funct3;
                        r_addr_lo <= req_addr[1:0];
                        req_ready <= 1'b0;
                        if (req_ok) begin
                            state     <= S_ACCESS;
                            cnt       <= CNT_W'(MEM_LATENCY);
                            mem_valid <= 1'b1;
                            mem_wen   <= req_wen;
                            mem_raddr <= {req_addr[31:2], 2'b00};
                            mem_waddr <= {req_addr[31:2], 2'b00};
                            mem_wdata <= req_wen ? st_wdata : 32'h0;
                            mem_wmask <= req_wen ? {4'b0000, st_wmask} : 8'h00;
                        end else begin
                            // Rejected requests never touch memory.
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= 32'h0;
                            resp_err   <= 1'b1;
                        end
                    end
                end

                S_ACCESS: begin
                    // Write strobe only in the first beat so a long access
                    // cannot repeat the store.
                    mem_wen <= 1'b0;
                    cnt     <= cnt - CNT_W'(1);
                    if (last_beat) begin
                        state      <= S_RESP;
                        mem_valid  <= 1'b0;
                        mem_raddr  <= 32'h0;
                        mem_waddr  <= 32'h0;
                        mem_wdata  <= 32'h0;
                        mem_wmask  <= 8'h00;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= r_wen ? 32'h0 : ld_data;
                    end
                end

                S_RESP: begin
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'h0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
